// File: rtl/fsqrt_iter_if.sv
// Handshake bundle for the iterative square-root unit.
//   in_valid/in_ready/x       : operand channel (master drives, unit accepts)
//   out_valid/out_ready/y/nv  : result channel (unit drives, master consumes)
// The master modport is the issuing side; the slave modport is the sqrt unit.
interface fsqrt_iter_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         flag_nv;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, flag_nv
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, flag_nv
    );
endinterface

// File: rtl/fsqrt_iter.sv
// Iterative IEEE-754 square root, round-to-nearest-even, denormals flushed.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-high reset, discards any in-flight operation
//   bus  - fsqrt_iter_if.slave: operand x in, result y / flag_nv out,
//          valid/ready on both sides
// The root is produced by a restoring digit recurrence, BITS_PER_CYCLE root
// bits per CALC cycle, then rounded and packed in one ROUND cycle.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand
// CALC  | digit recurrence, counter N_ITER-1 down to 0
// ROUND | RNE rounding and result packing
// DONE  | out_valid=1, result held until out_ready
module fsqrt_iter #(
    parameter int EXP_W          = 8,
    parameter int MAN_W          = 23,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    fsqrt_iter_if.slave   bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int M      = MAN_W + 2;                     // root bits kept: 1.fff + guard
    localparam int N_ITER = (M + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int MT     = N_ITER * BITS_PER_CYCLE;       // root bits actually resolved
    localparam int RAD_W  = 2 * MT;
    localparam int REM_W  = MT + 3;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    localparam logic [W-1:0] QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] P_INF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [MT-1:0]      root_q, root_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [W-1:0]       y_q, y_d;
    logic               nv_q, nv_d;

    // operand fields
    logic               sign_in;
    logic [EXP_W-1:0]   exp_in;
    logic [MAN_W-1:0]   frac_in;
    logic [M-1:0]       rad_top;
    logic [EXP_W:0]     exp_sum;

    assign sign_in = bus.x[W-1];
    assign exp_in  = bus.x[W-2 -: EXP_W];
    assign frac_in = bus.x[MAN_W-1:0];

    // BIAS is odd, so the unbiased exponent is odd exactly when E is even;
    // then the radicand is doubled to bring it into [2,4).
    assign rad_top = exp_in[0] ? {2'b01, frac_in} : {1'b1, frac_in, 1'b0};
    // (E-BIAS)/2 + BIAS, with the odd case rounded down, equals floor((E+BIAS)/2).
    assign exp_sum = {1'b0, exp_in} + (EXP_W+1)'(BIAS);

    // recurrence step, unrolled BITS_PER_CYCLE times
    logic [REM_W-1:0]   step_rem;
    logic [MT-1:0]      step_root;
    logic [RAD_W-1:0]   step_rad;
    logic [REM_W-1:0]   rem_t;
    logic [REM_W-1:0]   trial;

    always_comb begin
        step_rem  = rem_q;
        step_root = root_q;
        step_rad  = rad_q;
        rem_t     = '0;
        trial     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_t = {step_rem[REM_W-3:0], step_rad[RAD_W-1 -: 2]};
            trial = {1'b0, step_root, 2'b01};
            if (rem_t >= trial) begin
                step_rem  = rem_t - trial;
                step_root = {step_root[MT-2:0], 1'b1};
            end else begin
                step_rem  = rem_t;
                step_root = {step_root[MT-2:0], 1'b0};
            end
            step_rad = step_rad << 2;
        end
    end

    // rounding
    logic [M-1:0]       root_m;
    logic [MT-1:0]      lo_bits;
    logic               sticky;
    logic               rnd_up;
    logic [M-1:0]       rounded;
    logic               carry;
    logic [MAN_W-1:0]   frac_out;

    always_comb begin
        root_m   = root_q[MT-1 -: M];
        // excess low root bits (only when BITS_PER_CYCLE does not divide M)
        // count toward sticky, never toward the mantissa
        lo_bits  = root_q << M;
        sticky   = (rem_q != '0) || (lo_bits != '0);
        rnd_up   = root_m[0] & (sticky | root_m[1]);
        rounded  = {1'b0, root_m[M-1:1]} + M'(rnd_up);
        carry    = rounded[M-1];
        frac_out = MAN_W'(rounded);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        exp_d   = exp_q;
        y_d     = y_q;
        nv_d    = nv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    nv_d = 1'b0;
                    if (exp_in == '0) begin
                        y_d     = {sign_in, {(W-1){1'b0}}};
                        state_d = S_DONE;
                    end else if (exp_in == '1 && frac_in != '0) begin
                        y_d     = QNAN;
                        state_d = S_DONE;
                    end else if (sign_in) begin
                        y_d     = QNAN;
                        nv_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (exp_in == '1) begin
                        y_d     = P_INF;
                        state_d = S_DONE;
                    end else begin
                        rad_d   = {rad_top, {(RAD_W-M){1'b0}}};
                        rem_d   = '0;
                        root_d  = '0;
                        exp_d   = EXP_W'(exp_sum >> 1);
                        cnt_d   = CNT_W'(N_ITER - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rad_d  = step_rad;
                rem_d  = step_rem;
                root_d = step_root;
                if (cnt_q == '0) begin
                    state_d = S_ROUND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ROUND: begin
                y_d     = {1'b0, exp_q + EXP_W'(carry), frac_out};
                nv_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            exp_q   <= '0;
            y_q     <= '0;
            nv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            exp_q   <= exp_d;
            y_q     <= y_d;
            nv_q    <= nv_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.y         = y_q;
    assign bus.flag_nv   = nv_q;

endmodule
